// File: rtl/fakeram_pkg.sv
// Shared geometry constants for the fakeram130 macro variants and the
// request-port controller state type.
package fakeram_pkg;

  localparam int FR512X64_BITS       = 64;
  localparam int FR512X64_WORD_DEPTH = 512;
  localparam int FR512X64_ADDR_WIDTH = 9;

  localparam int FR256X32_BITS       = 32;
  localparam int FR256X32_WORD_DEPTH = 256;
  localparam int FR256X32_ADDR_WIDTH = 8;

  localparam int FR256X48_BITS       = 48;
  localparam int FR256X48_WORD_DEPTH = 256;
  localparam int FR256X48_ADDR_WIDTH = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } port_state_t;

endpackage

// File: rtl/fakeram130_512x64.sv
// Behavioural model of the fakeram130 512x64 single-port macro:
// synchronous read with 1-cycle latency, bit-masked synchronous write.
module fakeram130_512x64 (
  input  logic        clk,
  output logic [63:0] rd_out,
  input  logic [8:0]  addr_in,
  input  logic        we_in,
  input  logic [63:0] wd_in,
  input  logic [63:0] w_mask_in,
  input  logic        ce_in
);

  logic [63:0] mem [512];

  always_ff @(posedge clk) begin
    if (ce_in) begin
      if (we_in) begin
        mem[addr_in] <= (wd_in & w_mask_in) | (mem[addr_in] & ~w_mask_in);
      end else begin
        rd_out <= mem[addr_in];
      end
    end
  end

endmodule

// File: rtl/fakeram_rsp_fifo.sv
// Small response FIFO with wrapping pointers and an occupancy count.
module fakeram_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage is reset too so the head never presents X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (count == '0)));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/fakeram_req_port.sv
// Initiator-side port for a fakeram130 macro: valid/ready requests in,
// macro pins out, 1-cycle read data captured into a response queue.
module fakeram_req_port
  import fakeram_pkg::*;
#(
  parameter int BITS           = FR512X64_BITS,
  parameter int WORD_DEPTH     = FR512X64_WORD_DEPTH,
  parameter int ADDR_WIDTH     = FR512X64_ADDR_WIDTH,
  parameter int CLEAR_ON_RESET = 1,
  parameter int RSP_DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BITS-1:0]       req_wdata,
  input  logic [BITS-1:0]       req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BITS-1:0]       rsp_rdata,
  output logic                  init_done,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [BITS-1:0]       sram_wd,
  output logic [BITS-1:0]       sram_wmask,
  input  logic [BITS-1:0]       sram_rd
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  port_state_t           state_q;
  port_state_t           state_d;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  sweep_last;
  logic                  inflight;
  logic                  accept_ok;
  logic                  fire;
  logic                  pop;
  logic [CW-1:0]         q_count;

  assign sweep_last = (init_cnt == ADDR_WIDTH'(WORD_DEPTH - 1));

  // Credits cover both queued data and the read still inside the macro.
  assign accept_ok = (state_q == RUN) &&
                     ((int'(q_count) + int'(inflight)) < RSP_DEPTH);
  assign fire      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = (q_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == INIT) && sweep_last) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      if (state_q == INIT) begin
        init_cnt <= sweep_last ? '0 : init_cnt + 1'b1;
      end
      inflight <= fire && !req_we;
    end
  end

  // Macro pins are held at zero while reset is asserted.
  always_comb begin
    req_ready  = 1'b0;
    init_done  = (state_q == RUN);
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wd    = '0;
    sram_wmask = '0;
    if (rst_n) begin
      unique case (state_q)
        INIT: begin
          sram_ce    = 1'b1;
          sram_we    = 1'b1;
          sram_addr  = init_cnt;
          sram_wmask = '1;
        end
        RUN: begin
          req_ready = accept_ok;
          if (req_valid && accept_ok) begin
            sram_ce    = 1'b1;
            sram_we    = req_we;
            sram_addr  = req_addr;
            sram_wd    = req_wdata;
            sram_wmask = req_wmask;
          end
        end
        default: begin
          req_ready = 1'b0;
        end
      endcase
    end
  end

  fakeram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (BITS),
    .CW    (CW)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (sram_rd),
    .pop       (pop),
    .head      (rsp_rdata),
    .count     (q_count)
  );

endmodule

// File: tb/tb_fakeram_req_port.sv
// Randomised bench for fakeram_req_port driving the fakeram130_512x64 model,
// checked against a queue/array reference of the port's behaviour.
module tb_fakeram_req_port;
  import fakeram_pkg::*;

  localparam int BITS  = FR512X64_BITS;
  localparam int DEPTH = FR512X64_WORD_DEPTH;
  localparam int AW    = FR512X64_ADDR_WIDTH;
  localparam int RSPD  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [BITS-1:0] req_wdata;
  logic [BITS-1:0] req_wmask;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [BITS-1:0] rsp_rdata;
  logic            init_done;
  logic            sram_ce;
  logic            sram_we;
  logic [AW-1:0]   sram_addr;
  logic [BITS-1:0] sram_wd;
  logic [BITS-1:0] sram_wmask;
  logic [BITS-1:0] sram_rd;

  always #5 clk = ~clk;

  fakeram_req_port #(
    .BITS           (BITS),
    .WORD_DEPTH     (DEPTH),
    .ADDR_WIDTH     (AW),
    .CLEAR_ON_RESET (1),
    .RSP_DEPTH      (RSPD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .init_done  (init_done),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wd    (sram_wd),
    .sram_wmask (sram_wmask),
    .sram_rd    (sram_rd)
  );

  fakeram130_512x64 u_macro (
    .clk       (clk),
    .rd_out    (sram_rd),
    .addr_in   (sram_addr),
    .we_in     (sram_we),
    .wd_in     (sram_wd),
    .w_mask_in (sram_wmask),
    .ce_in     (sram_ce)
  );

  int errors = 0;
  int checks = 0;

  // Reference: memory image, visible responses, and the one read in flight.
  logic [BITS-1:0] ref_mem [DEPTH];
  logic [BITS-1:0] rsp_q [$];
  bit              pend_valid;
  logic [BITS-1:0] pend_data;
  bit              ref_run;
  bit              last_fire;
  int              dut_fires;

  task automatic check_val(input string tag, input logic [BITS-1:0] got,
                           input logic [BITS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rsp_q.delete();
    pend_valid = 1'b0;
    ref_run    = 1'b0;
  endtask

  // Called at a negedge: checks state outputs, drives one cycle of stimulus,
  // checks the macro pins, then advances the reference across the posedge.
  task automatic step(input bit v, input bit we, input logic [AW-1:0] addr,
                      input logic [BITS-1:0] wd, input logic [BITS-1:0] wm,
                      input bit rr);
    bit exp_ready;
    bit fire;
    bit pop;
    exp_ready = ref_run && ((rsp_q.size() + int'(pend_valid)) < RSPD);
    check_val("req_ready", req_ready, exp_ready);
    check_val("rsp_valid", rsp_valid, rsp_q.size() != 0);
    if (rsp_q.size() != 0) check_val("rsp_rdata", rsp_rdata, rsp_q[0]);
    check_val("init_done", init_done, ref_run);
    req_valid = v; req_we = we; req_addr = addr;
    req_wdata = wd; req_wmask = wm; rsp_ready = rr;
    #1;
    fire = v && exp_ready;
    if (req_valid && req_ready) dut_fires++;
    check_val("sram_ce", sram_ce, fire);
    check_val("sram_we", sram_we, fire && we);
    check_val("sram_addr", sram_addr, fire ? addr : '0);
    check_val("sram_wd", sram_wd, fire ? wd : '0);
    check_val("sram_wmask", sram_wmask, fire ? wm : '0);
    pop = (rsp_q.size() != 0) && rr;
    last_fire = fire;
    @(posedge clk);
    if (pop) void'(rsp_q.pop_front());
    if (pend_valid) rsp_q.push_back(pend_data);
    pend_valid = fire && !we;
    if (pend_valid) pend_data = ref_mem[addr];
    if (fire && we) ref_mem[addr] = (wd & wm) | (ref_mem[addr] & ~wm);
    @(negedge clk);
  endtask

  task automatic idle(input bit rr);
    step(1'b0, 1'b0, '0, '0, '0, rr);
  endtask

  // Checks n cycles of the clear sweep starting at address 0.
  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      check_val("sweep_ce", sram_ce, 1);
      check_val("sweep_we", sram_we, 1);
      check_val("sweep_addr", sram_addr, BITS'(i));
      check_val("sweep_wd", sram_wd, '0);
      check_val("sweep_wmask", sram_wmask, '1);
      check_val("sweep_ready", req_ready, 0);
      check_val("sweep_done", init_done, 0);
      check_val("sweep_rsp", rsp_valid, 0);
      @(negedge clk);
    end
  endtask

  task automatic sweep_finished();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_run = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ce"}, sram_ce, 0);
    check_val({tag, "_we"}, sram_we, 0);
    check_val({tag, "_addr"}, sram_addr, 0);
    check_val({tag, "_wmask"}, sram_wmask, 0);
    check_val({tag, "_ready"}, req_ready, 0);
    check_val({tag, "_rsp"}, rsp_valid, 0);
    check_val({tag, "_done"}, init_done, 0);
  endtask

  initial begin
    logic [BITS-1:0] wd;
    logic [BITS-1:0] wm;
    int acc;
    int guard;
    int f0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b0;
    dut_fires = 0; last_fire = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    sweep(DEPTH);
    sweep_finished();

    // Top word is zero after the sweep.
    step(1'b1, 1'b0, 9'h1FF, '0, '0, 1'b0);
    idle(1'b0);
    check_val("rd_1ff_valid", rsp_valid, 1);
    check_val("rd_1ff_data", rsp_rdata, 64'h0);
    idle(1'b1);

    // Write then read on the next cycle, then a partial-mask merge.
    step(1'b1, 1'b1, 9'h005, 64'hDEADBEEF_CAFEF00D, '1, 1'b1);
    step(1'b1, 1'b0, 9'h005, '0, '0, 1'b0);
    idle(1'b0);
    check_val("wr_rd_valid", rsp_valid, 1);
    check_val("wr_rd_data", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
    idle(1'b1);
    step(1'b1, 1'b1, 9'h005, 64'h0, 64'h0000_0000_FFFF_FFFF, 1'b1);
    step(1'b1, 1'b0, 9'h005, '0, '0, 1'b0);
    idle(1'b0);
    check_val("merge_data", rsp_rdata, 64'hDEADBEEF_00000000);
    idle(1'b1);

    // Distinct data at 0x10..0x17, then a stream of reads held valid.
    for (int i = 0; i < 8; i++) begin
      wd = {$urandom, $urandom};
      step(1'b1, 1'b1, AW'(9'h010 + i), wd, '1, 1'b1);
    end
    acc = 0; guard = 0;
    while (acc < 8 && guard < 40) begin
      step(1'b1, 1'b0, AW'(9'h010 + acc), '0, '0, 1'b1);
      if (last_fire) acc++;
      guard++;
    end
    check_val("b2b_accepted", BITS'(acc), 8);
    repeat (4) idle(1'b1);

    // Backpressure: only RSP_DEPTH reads accepted, then drain in order.
    f0 = dut_fires;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, AW'(9'h010 + i), '0, '0, 1'b0);
    check_val("bp_accepted", BITS'(dut_fires - f0), 2);
    check_val("bp_ready_low", req_ready, 0);
    idle(1'b1);
    idle(1'b1);
    check_val("bp_ready_back", req_ready, 1);

    // Random traffic on a small address window to provoke address reuse.
    for (int i = 0; i < 2000; i++) begin
      wm = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : '1;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 15)), {$urandom, $urandom}, wm,
           $urandom_range(0, 9) < 7);
    end

    // Asynchronous reset with traffic pending, then again mid-sweep at 200.
    step(1'b1, 1'b0, 9'h003, '0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_run");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    sweep(200);
    #1 check_val("mid_addr", sram_addr, 200);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_sweep");
    @(negedge clk);
    rst_n = 1'b1;
    sweep(DEPTH);
    sweep_finished();

    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 7)), {$urandom, $urandom},
           {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
